// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR with a warm-up phase, load with zero-seed
// substitution, and a pulse each time the sequence returns to its start value.
module lfsr_gen #(
    parameter int unsigned       WIDTH  = 12,
    parameter logic [WIDTH-1:0]  TAPS   = 12'hE08,
    parameter logic [WIDTH-1:0]  SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned       WARMUP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             ready,
    output logic             wrap,
    output logic             seed_fault
);

    typedef enum logic {WARM = 1'b0, RUN = 1'b1} fsm_t;

    localparam logic [7:0] WARMUP_C = 8'(WARMUP);

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] start_q;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_inc;
    logic             step;
    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lfsr_nxt;
    logic             seed_zero;
    logic [WIDTH-1:0] load_val;

    // load wins over en; a step only happens without a load
    assign step      = en & ~load;
    assign fb        = ^(lfsr_q & TAPS);
    assign shifted   = {lfsr_q[WIDTH-2:0], fb};
    // a singular TAPS mask could shift into zero; reseed rather than lock up
    assign lfsr_nxt  = (shifted == '0) ? SEED : shifted;
    assign seed_zero = (seed_in == '0);
    assign load_val  = seed_zero ? SEED : seed_in;
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= WARM;
        else     fsm_q <= fsm_d;
    end

    // FSM next state: load restarts warm-up, enough warm steps promote to RUN
    always_comb begin
        fsm_d = fsm_q;
        if (load) begin
            fsm_d = WARM;
        end else if (fsm_q == WARM) begin
            if (WARMUP_C == 8'd0)
                fsm_d = RUN;
            else if (en && cnt_inc == WARMUP_C)
                fsm_d = RUN;
        end
    end

    // FSM outputs: ready decodes the state register only, no path from en
    always_comb begin
        ready = (fsm_q == RUN);
    end

    // warm counter: counts steps while warming, clears on load, saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 8'd0;
        else if (load)
            cnt_q <= 8'd0;
        else if (step && fsm_q == WARM)
            cnt_q <= cnt_inc;
    end

    // shift register and start value capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= SEED;
            start_q <= SEED;
        end else if (load) begin
            lfsr_q  <= load_val;
            start_q <= load_val;
        end else if (step) begin
            lfsr_q  <= lfsr_nxt;
        end
    end

    // one-cycle status pulses, cleared by any cycle without a matching event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap       <= 1'b0;
            seed_fault <= 1'b0;
        end else begin
            wrap       <= step && (lfsr_nxt == start_q);
            seed_fault <= load && seed_zero;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: checks lfsr_gen against an arithmetic reference model
// (12-bit default instance) and a hand table (4-bit instance).
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, load = 1'b0;
    logic [11:0] seed_in = '0;
    logic [11:0] out12;
    logic        ready12, wrap12, fault12;
    logic        en4 = 1'b0, load4 = 1'b0;
    logic [3:0]  seed4 = '0;
    logic [3:0]  out4;
    logic        ready4, wrap4, fault4;

    int total = 0;
    int bad   = 0;

    // reference model state for the 12-bit instance
    int m_s, m_start, m_steps;
    bit m_wrap, m_fault;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(12), .TAPS(12'hE08), .SEED(12'h001), .WARMUP(16)) dut12 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .lfsr_out(out12), .ready(ready12), .wrap(wrap12), .seed_fault(fault12));

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .WARMUP(16)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .load(load4), .seed_in(seed4),
        .lfsr_out(out4), .ready(ready4), .wrap(wrap4), .seed_fault(fault4));

    // next value: double, add parity of tapped bits, drop the overflow bit
    function automatic int nxt(int x, int taps, int modulus);
        return (x * 2 + ($countones(x & taps) % 2)) % modulus;
    endfunction

    task automatic model_reset();
        m_s = 1; m_start = 1; m_steps = 0; m_wrap = 0; m_fault = 0;
    endtask

    // apply one cycle of stimulus to the 12-bit instance and advance the model
    task automatic drive(bit e, bit l, int sd);
        en = e; load = l; seed_in = 12'(sd);
        @(posedge clk); #1;
        if (l) begin
            m_s = (sd == 0) ? 1 : sd;
            m_start = m_s; m_steps = 0; m_fault = (sd == 0); m_wrap = 0;
        end else if (e) begin
            m_s = nxt(m_s, 'hE08, 4096);
            m_wrap = (m_s == m_start); m_fault = 0;
            if (m_steps < 255) m_steps++;
        end else begin
            m_wrap = 0; m_fault = 0;
        end
        en = 0; load = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        total++; if (out12 !== 12'h001) begin bad++; $display("FAIL rst_out12: got %h want 001", out12); end
        total++; if (out4 !== 4'h1) begin bad++; $display("FAIL rst_out4: got %h want 1", out4); end
        total++; if ({ready12, wrap12, fault12} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {ready12, wrap12, fault12}); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_small_seq();
        int seq[7] = '{1, 2, 4, 9, 3, 6, 13};
        int s = 1;
        int wraps = 0;
        for (int i = 1; i <= 45; i++) begin
            en4 = 1'b1;
            @(posedge clk); #1;
            s = nxt(s, 'hC, 16);
            if (i < 7) begin
                total++; if (out4 !== 4'(seq[i])) begin bad++; $display("FAIL seq4_tab[%0d]: got %h want %h", i, out4, seq[i]); end
            end
            total++; if (out4 !== 4'(s)) begin bad++; $display("FAIL seq4_model[%0d]: got %h want %h", i, out4, s); end
            total++; if (wrap4 !== (i % 15 == 0)) begin bad++; $display("FAIL wrap4[%0d]: got %b want %b", i, wrap4, (i % 15 == 0)); end
            if (wrap4) wraps++;
        end
        en4 = 1'b0;
        total++; if (wraps != 3) begin bad++; $display("FAIL wrap4_count: got %0d want 3", wraps); end
    endtask

    task automatic test_warmup();
        int wraps = 0, wrap_at = 0;
        do_reset();
        for (int i = 1; i <= 4095; i++) begin
            drive(1, 0, 0);
            if (i == 15) begin
                total++; if (ready12 !== 1'b0) begin bad++; $display("FAIL ready_15: got %b want 0", ready12); end
            end
            if (i == 16) begin
                total++; if (ready12 !== 1'b1) begin bad++; $display("FAIL ready_16: got %b want 1", ready12); end
            end
            total++; if (out12 !== 12'(m_s)) begin bad++; $display("FAIL warm_out[%0d]: got %h want %h", i, out12, m_s); end
            total++; if (wrap12 !== m_wrap) begin bad++; $display("FAIL warm_wrap[%0d]: got %b want %b", i, wrap12, m_wrap); end
            if (wrap12) begin wraps++; wrap_at = i; end
        end
        total++; if (wraps != 1 || wrap_at != 4095) begin bad++; $display("FAIL period: got %0d wraps at %0d want 1 at 4095", wraps, wrap_at); end
    endtask

    task automatic test_zero_load();
        drive(0, 1, 0);
        total++; if (out12 !== 12'h001) begin bad++; $display("FAIL zload_out: got %h want 001", out12); end
        total++; if (fault12 !== 1'b1) begin bad++; $display("FAIL zload_fault: got %b want 1", fault12); end
        total++; if (ready12 !== 1'b0) begin bad++; $display("FAIL zload_ready: got %b want 0", ready12); end
        drive(0, 0, 0);
        total++; if (fault12 !== 1'b0) begin bad++; $display("FAIL zload_fault_pulse: got %b want 0", fault12); end
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 0);
            total++; if (ready12 !== (i >= 16)) begin bad++; $display("FAIL zload_rewarm[%0d]: got %b want %b", i, ready12, (i >= 16)); end
        end
    endtask

    task automatic test_load_en();
        int wraps = 0, wrap_at = 0;
        drive(1, 1, 'hABC);
        total++; if (out12 !== 12'hABC) begin bad++; $display("FAIL load_en_out: got %h want abc", out12); end
        total++; if ({wrap12, fault12, ready12} !== 3'b000) begin bad++; $display("FAIL load_en_flags: got %b want 000", {wrap12, fault12, ready12}); end
        for (int i = 1; i <= 4095; i++) begin
            drive(1, 0, 0);
            if (wrap12) begin wraps++; wrap_at = i; end
            total++; if (out12 !== 12'(m_s)) begin bad++; $display("FAIL load_run_out[%0d]: got %h want %h", i, out12, m_s); end
        end
        total++; if (wraps != 1 || wrap_at != 4095) begin bad++; $display("FAIL load_period: got %0d wraps at %0d want 1 at 4095", wraps, wrap_at); end
        total++; if (out12 !== 12'hABC) begin bad++; $display("FAIL load_return: got %h want abc", out12); end
    endtask

    task automatic test_async_rst();
        total++; if (ready12 !== 1'b1) begin bad++; $display("FAIL pre_rst_ready: got %b want 1", ready12); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out12 !== 12'h001) begin bad++; $display("FAIL arst_out: got %h want 001", out12); end
        total++; if ({ready12, wrap12, fault12} !== 3'b000) begin bad++; $display("FAIL arst_flags: got %b want 000", {ready12, wrap12, fault12}); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive(1, 0, 0);
        total++; if (out12 !== 12'h002) begin bad++; $display("FAIL resume_step: got %h want 002", out12); end
    endtask

    task automatic test_hold();
        logic [11:0] held;
        for (int i = 0; i < 16; i++) drive(1, 0, 0);
        held = out12;
        total++; if (held !== 12'(m_s)) begin bad++; $display("FAIL hold_start: got %h want %h", held, m_s); end
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0);
            total++; if (out12 !== held || wrap12 !== 1'b0 || ready12 !== 1'b1 || fault12 !== 1'b0) begin
                bad++; $display("FAIL hold[%0d]: got out=%h w=%b r=%b f=%b want out=%h w=0 r=1 f=0", i, out12, wrap12, ready12, fault12, held);
            end
        end
    endtask

    task automatic test_random();
        bit e, l;
        int sd;
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 9) < 7);
            l  = ($urandom_range(0, 29) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 4095));
            drive(e, l, sd);
            total++; if (out12 !== 12'(m_s)) begin bad++; $display("FAIL rnd_out[%0d]: got %h want %h", i, out12, m_s); end
            total++; if (ready12 !== (m_steps >= 16)) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready12, (m_steps >= 16)); end
            total++; if (wrap12 !== m_wrap) begin bad++; $display("FAIL rnd_wrap[%0d]: got %b want %b", i, wrap12, m_wrap); end
            total++; if (fault12 !== m_fault) begin bad++; $display("FAIL rnd_fault[%0d]: got %b want %b", i, fault12, m_fault); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_small_seq();
        test_warmup();
        test_zero_load();
        test_load_en();
        test_async_rst();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
- REQ-001: Parameter WIDTH, default 12: state/output width in bits; legal range 4..32.
- REQ-002: Parameter TAPS, default 12'hE08: feedback mask; bit i set means state[i] is XORed into the feedback. The default is x^12+x^11+x^10+x^4+1.
- REQ-003: Parameter SEED, default 1: reset seed and zero-seed substitute; SHALL be nonzero.
- REQ-004: Parameter WARMUP, default 16: number of steps after reset/load before `ready` asserts; legal range 0..255.
- REQ-005: `clk`, input, 1 bit: single clock; all state SHALL change on its rising edge.
- REQ-006: `rst`, input, 1 bit: reset, asynchronous and active-high.
- REQ-007: `en`, input, 1 bit: advance the LFSR one step this cycle.
- REQ-008: `load`, input, 1 bit: load `seed_in` this cycle.
- REQ-009: `seed_in`, input, WIDTH bits: seed value for `load`.
- REQ-010: `lfsr_out`, output, WIDTH bits: current state, registered.
- REQ-011: `ready`, output, 1 bit: warm-up complete.
- REQ-012: `wrap`, output, 1 bit: one-cycle pulse when the sequence returns to its start value.
- REQ-013: `seed_fault`, output, 1 bit: one-cycle pulse when a zero seed was substituted.

Function
- REQ-014: Feedback fb = XOR-reduce(state & TAPS); on a step, next state = {state[WIDTH-2:0], fb} (Fibonacci, shift left).
- REQ-015: The FSM SHALL have states WARM and RUN; reset and every `load` enter WARM.
- REQ-016: In WARM, each `en` step SHALL increment an 8-bit warm counter; when the count reaches WARMUP, the FSM SHALL go to RUN. With WARMUP=0, it SHALL go to RUN on the cycle after entering WARM.
- REQ-017: `ready` SHALL be 1 exactly while in RUN, registered, with no combinational path from `en`.
- REQ-018: `load` SHALL have priority over `en` in the same cycle. On load the state becomes `seed_in` (or SEED if `seed_in`==0), the warm counter clears, and no step occurs.
- REQ-019: A zero `seed_in` on load SHALL substitute SEED and assert `seed_fault` for exactly the next cycle.
- REQ-020: The start value (SEED after reset, or the loaded/substituted value) SHALL be captured in a register.
- REQ-021: `wrap` SHALL pulse for one cycle, in the cycle after a step whose next state equals the start value. It SHALL be valid in both WARM and RUN.
- REQ-022: With `en`=0 and `load`=0, the state, counter, FSM and start register SHALL hold, and `wrap`/`seed_fault` SHALL be 0.
- REQ-023: The state SHALL never be all-zero. With a maximal TAPS, the period SHALL be 2^WIDTH-1 steps.
- REQ-024: The warm counter SHALL saturate; it SHALL NOT wrap while in RUN.

Reset
- REQ-025: On `rst`=1, immediately and asynchronously: `lfsr_out`=SEED, start=SEED, counter=0, FSM=WARM, `ready`=0, `wrap`=0, `seed_fault`=0.
- REQ-026: `rst` asserted mid-warm-up or mid-run SHALL abort all activity. Stepping SHALL resume on the first `en` after the `rst` deassertion edge.

Verification
- REQ-027: WIDTH=4, TAPS=4'hC, SEED=1; reset, then `en` held high -> `lfsr_out` shows 1,2,4,9,3,6,D,...; `wrap` pulses once after exactly 15 steps, and every 15 steps thereafter.
- REQ-028: Default parameters, WARMUP=16; reset, then 15 `en` pulses -> `ready`=0; 16th pulse -> `ready`=1 on the next cycle; 4095 steps -> single `wrap`.
- REQ-029: `load`=1 with `seed_in`=0 -> `lfsr_out`=SEED, `seed_fault`=1 for one cycle, `ready`=0, counter restarted.
- REQ-030: `load` and `en` in the same cycle with `seed_in`=12'hABC -> `lfsr_out`=12'hABC (no step); `wrap` fires after 4095 further steps.
- REQ-031: `rst` asserted asynchronously between clock edges while in RUN -> outputs reach reset values before the next edge; `ready`=0.
- REQ-032: `en`=0 for 100 cycles in RUN -> `lfsr_out` constant, `wrap`=0, `ready` stays 1.
